// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit owning the HI/LO registers
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] rdata
);
  localparam int CW = $clog2(MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] pend_hi, pend_lo, ua, ub, uq, ur, sq, sr;
  logic [63:0] smul, umul, res;
  assign busy = state == RUN;
  assign start = en && op >= 4'd1 && op <= 4'd4 && !busy;
  assign rdata = op == 4'd5 ? HI : op == 4'd6 ? LO : 32'd0;
  always_comb begin
    smul = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    umul = {32'd0, A} * {32'd0, B};
    ua = op == 4'd3 && A[31] ? -A : A;
    ub = op == 4'd3 && B[31] ? -B : B;
    uq = ub == 32'd0 ? 32'd0 : ua / ub;
    ur = ub == 32'd0 ? 32'd0 : ua % ub;
    sq = A[31] ^ B[31] ? -uq : uq;
    sr = A[31] ? -ur : ur;
    res = op == 4'd1 ? smul : op == 4'd2 ? umul : B == 32'd0 ? {HI, LO} :
          op == 4'd3 ? {sr, sq} : {ur, uq};
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      HI <= '0;
      LO <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        {pend_hi, pend_lo} <= res;
        cnt <= op <= 4'd2 ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        state <= RUN;
      end else if (en && op == 4'd7) HI <= A;
      else if (en && op == 4'd8) LO <= A;
    end else begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        HI <= pend_hi;
        LO <= pend_lo;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: randomized and directed checks of mdu_unit against a behavioural model
module tb_mdu_unit;
  localparam int MC = 5;
  localparam int DC = 10;
  logic clk = 0, reset = 0, en = 0, start, busy;
  logic [3:0] op = 0;
  logic [31:0] A = 0, B = 0, HI, LO, rdata;
  int n_chk = 0, n_fail = 0;
  logic [31:0] mhi = 0, mlo = 0;
  logic [63:0] mpend = 0;
  int mcnt = 0;
  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .A(A), .B(B),
    .start(start), .busy(busy), .HI(HI), .LO(LO), .rdata(rdata)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [63:0] mdl(input logic [3:0] o, input logic [31:0] a, b, hi, lo);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned xa = 64'(a);
    longint unsigned xb = 64'(b);
    if (o == 1) return 64'(sa * sb);
    if (o == 2) return xa * xb;
    if (b == 0) return {hi, lo};
    if (o == 3) return {32'(sa % sb), 32'(sa / sb)};
    return {32'(xa % xb), 32'(xa / xb)};
  endfunction
  task automatic cyc(input logic e, input logic [3:0] o, input logic [31:0] a, b, input logic r);
    logic s;
    en = e; op = o; A = a; B = b; reset = r;
    #1;
    s = e && o >= 1 && o <= 4 && mcnt == 0;
    check("start", 32'(start), 32'(s));
    check("rdata", rdata, o == 5 ? mhi : o == 6 ? mlo : 32'd0);
    @(posedge clk);
    if (!r) begin
      mhi = 0; mlo = 0; mcnt = 0;
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) {mhi, mlo} = mpend;
    end else if (s) begin
      mpend = mdl(o, a, b, mhi, mlo);
      mcnt = o <= 2 ? MC : DC;
    end else if (e && o == 7) mhi = a;
    else if (e && o == 8) mlo = a;
    @(negedge clk);
    check("busy", 32'(busy), 32'(mcnt > 0));
    check("hi", HI, mhi);
    check("lo", LO, mlo);
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 1);
  endtask
  initial begin
    @(negedge clk);
    cyc(0, 0, 0, 0, 0);
    check("rst_hi", HI, 0);
    cyc(1, 1, 32'hFFFFFFFF, 2, 1);
    idle(MC);
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFFE);
    cyc(1, 2, 32'hFFFFFFFF, 2, 1);
    idle(MC);
    check("multu_hi", HI, 32'h1);
    check("multu_lo", LO, 32'hFFFFFFFE);
    cyc(1, 3, 32'hFFFFFFF9, 2, 1);
    idle(DC);
    check("div_lo", LO, 32'hFFFFFFFD);
    check("div_hi", HI, 32'hFFFFFFFF);
    cyc(1, 4, 7, 2, 1);
    idle(DC);
    check("divu_lo", LO, 3);
    check("divu_hi", HI, 1);
    cyc(1, 3, 32'h80000000, 32'hFFFFFFFF, 1);
    idle(DC);
    check("ovf_lo", LO, 32'h80000000);
    check("ovf_hi", HI, 0);
    cyc(1, 7, 32'h11, 0, 1);
    cyc(1, 8, 32'h22, 0, 1);
    cyc(1, 3, 32'h55, 0, 1);
    idle(DC);
    check("dz_hi", HI, 32'h11);
    check("dz_lo", LO, 32'h22);
    cyc(1, 7, 32'h1234, 0, 1);
    cyc(1, 5, 0, 0, 1);
    check("mfhi", rdata, 32'h1234);
    check("mthi_lo", LO, 32'h22);
    cyc(1, 8, 32'h5678, 0, 1);
    cyc(1, 6, 0, 0, 1);
    check("mflo", rdata, 32'h5678);
    check("mtlo_hi", HI, 32'h1234);
    cyc(1, 1, 3, 4, 1);
    idle(2);
    cyc(0, 0, 0, 0, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_lo", LO, 0);
    idle(MC + 3);
    check("no_late_lo", LO, 0);
    cyc(0, 1, 5, 5, 1);
    check("en0_busy", 32'(busy), 0);
    cyc(1, 1, 6, 7, 1);
    cyc(1, 1, 100, 100, 1);
    cyc(1, 7, 32'hDEAD, 0, 1);
    idle(MC - 2);
    check("b2b_lo", LO, 42);
    check("b2b_hi", HI, 0);
    cyc(1, 3, 100, 7, 1);
    idle(DC);
    check("b2b_div_lo", LO, 14);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, b;
      a = $urandom_range(0, 3) == 0 ? $urandom_range(0, 20) - 10 : $urandom;
      b = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 3) == 0 ? $urandom_range(0, 20) - 10 : $urandom;
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
      if ($urandom_range(0, 9) == 0) b = 32'hFFFFFFFF;
      cyc($urandom_range(0, 4) != 0, 4'($urandom_range(0, 15)), a, b, $urandom_range(0, 199) != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit (MDU) in the E stage of the 5-stage MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU and MFHI/MFLO/MTHI/MTLO, and owns the HI/LO registers.
- Drives `start`/`busy` into the hazard unit; the hazard unit stalls D-stage MDU instructions while `start||busy`.
- Operands arrive already forwarded from the E-stage forwarding muxes.

Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU (must be ≥1).
- DIV_CYCLES, 10, busy duration for DIV/DIVU (must be ≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  E-stage instruction valid (not flushed/bubble).
- op  in  4  MDU opcode: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9–15 are treated as NOP.
- A  in  32  rs operand (forwarded).
- B  in  32  rt operand (forwarded).
- start  out  1  combinational; high in the issue cycle of a mult/div.
- busy  out  1  registered; high while an operation is in flight.
- HI  out  32  HI register.
- LO  out  32  LO register.
- rdata  out  32  combinational; HI when op=MFHI, LO when op=MFLO, else 0.

Behaviour:

Reset (sampled at clk edge while reset==0):
- busy, counter, HI, LO, and the pending result registers all go to 0.
- Overrides every other action in the same edge.
- An in-flight operation is discarded with no late HI/LO write.

Issue:
- start = en && op∈{1..4} && !busy. It depends on en, op and busy only.

States: IDLE (busy=0) and RUN (busy=1); the counter is $clog2(max(MULT_CYCLES,DIV_CYCLES))+1 bits.

IDLE, edge with start=1:
- Compute the result from the current A/B into pend_hi/pend_lo.
- counter <= MULT_CYCLES or DIV_CYCLES.
- busy <= 1, go to RUN.

IDLE, edge with en, op=MTHI:
- HI <= A. LO unchanged.

IDLE, edge with en, op=MTLO:
- LO <= A. HI unchanged.

IDLE, all other cases:
- No state change.

RUN, each edge:
- counter <= counter-1.
- When counter==1: HI<=pend_hi, LO<=pend_lo, busy<=0, go to IDLE.

Timing:
- busy is high for exactly N cycles after the start edge.
- New HI/LO are visible in the first cycle busy==0.
- A new start is legal in that same cycle (back-to-back).

Op arriving while busy:
- Any op with busy==1 is ignored: no start, no MTHI/MTLO write, no state change.
- The hazard unit guarantees this never happens.
- The verifier flags it as a protocol violation but still checks the ignore behaviour.

en==0:
- No start and no writes, regardless of op.

Arithmetic:
- MULT: signed 32x32→64; HI = [63:32], LO = [31:0].
- MULTU: unsigned 32x32→64, same split.
- DIV: LO = signed quotient truncated toward zero; HI = remainder, taking the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Divide by zero (B==0): pend_hi/pend_lo load the current HI/LO. busy still runs the full DIV_CYCLES, and HI/LO end up unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.

Reads:
- rdata reflects the current HI/LO registers (pre-edge values), so an MTHI and an MFHI issued in consecutive cycles see the updated value.
- rdata during busy returns the old HI/LO. D-stage stalling prevents this use.

Test Plan:
1. MULT: A=0xFFFFFFFF, B=0x00000002, en=1, op=1.
   - Required: start=1 that cycle; busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
   - Repeat with MULTU: HI=0x00000001, LO=0xFFFFFFFE.
2. DIV: A=0xFFFFFFF9 (-7), B=2.
   - Required: busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - DIVU with A=7, B=2: LO=3, HI=1.
   - DIV 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
3. Divide by zero: preload HI=0x11, LO=0x22 via MTHI/MTLO, then DIV with B=0.
   - Required: busy 10 cycles; afterwards HI=0x11, LO=0x22.
4. MTHI then MFHI: MTHI with A=0x00001234, next cycle op=MFHI.
   - Required: HI=0x1234 and rdata=0x00001234; LO unchanged.
   - MTLO then MFLO: same behaviour on LO.
5. Reset mid-operation: MULT 3*4, then reset=0 at the 3rd busy cycle.
   - Required: after that edge busy=0, HI=LO=0.
   - After reset is released, no write of 12 ever appears.
6. Gating and back-to-back:
   - en=0 with op=MULT: start=0, busy stays 0.
   - MULT issued while busy (cycle 2): ignored; the final result is from the first op only.
   - A new DIV issued in the first busy==0 cycle: starts immediately (start=1), producing busy for 10 more cycles.
